// File: rtl/clk_div_pkg.sv
// Shared defaults and the channel-index width helper for the clk_div_gen divider bank.
package clk_div_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_DIV   = 1000;

    // A single-channel bank still gets a 1-bit ld_ch port.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active ratio, pending-load slot, tick strobe and divided clock.
// Define CLK_DIV_TOGGLE_EN to build the clk_out toggle flop; otherwise clk_out is tied low.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_div,
    output logic             pending,
    output logic             tick,
    output logic             clk_out
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] pend_div;
    logic             running;
    logic             wrap;
    logic             apply;

    // A ratio of zero parks the channel; the compare is only meaningful for ratios >= 1.
    always_comb begin
        running = en && (div_reg != '0);
        wrap    = running && !sync && (cnt == div_reg - CNT_W'(1));
        apply   = pending && (sync || wrap || !running);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            div_reg  <= CNT_W'(DEFAULT_DIV);
            pending  <= 1'b0;
            pend_div <= '0;
            tick     <= 1'b0;
        end else begin
            tick <= wrap;
            if (apply) begin
                div_reg <= pend_div;
                pending <= 1'b0;
            end
            if (sync || apply || wrap) begin
                cnt <= '0;
            end else if (running) begin
                cnt <= cnt + CNT_W'(1);
            end
            // Accepts only arrive while the slot is empty, so they never collide with apply.
            if (ld) begin
                pending  <= 1'b1;
                pend_div <= ld_div;
            end
        end
    end

`ifdef CLK_DIV_TOGGLE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_out <= 1'b0;
        end else if (wrap) begin
            clk_out <= ~clk_out;
        end
    end
`else
    assign clk_out = 1'b0;
`endif

endmodule

// File: rtl/clk_div_gen.sv
// Bank of NUM_CH programmable clock dividers with a shared load port and sync realignment.
// Optional CLK_DIV_TOGGLE_EN builds 50%-duty clk_out toggles in each channel.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             en,
    input  logic                          sync,
    input  logic                          ld_valid,
    input  logic [ch_idx_w(NUM_CH)-1:0]   ld_ch,
    input  logic [CNT_W-1:0]              ld_div,
    output logic                          ld_ready,
    output logic [NUM_CH-1:0]             tick,
    output logic [NUM_CH-1:0]             clk_out
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] ld_sel;

    // NOTE: defaults come first in always_comb so no path leaves a signal unassigned (no latch).
    // An ld_ch beyond the bank matches no channel and therefore reads not-ready.
    always_comb begin
        ld_ready = 1'b0;
        ld_sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ld_ch == CH_W'(i)) begin
                ld_ready  = !pending[i];
                ld_sel[i] = ld_valid && !pending[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[g]),
            .sync    (sync),
            .ld      (ld_sel[g]),
            .ld_div  (ld_div),
            .pending (pending[g]),
            .tick    (tick[g]),
            .clk_out (clk_out[g])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed corner sequences, a vector table and a randomized run.
// Expectations for clk_out follow CLK_DIV_TOGGLE_EN as seen by this compile.
module tb_clk_div_gen;
    import clk_div_pkg::*;

    localparam int NUM_CH      = 3;
    localparam int CNT_W       = DEF_CNT_W;
    localparam int DEFAULT_DIV = DEF_DIV;
`ifdef CLK_DIV_TOGGLE_EN
    localparam bit TOGGLE = 1'b1;
`else
    localparam bit TOGGLE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] en;
    logic              sync;
    logic              ld_valid;
    logic [1:0]        ld_ch;
    logic [CNT_W-1:0]  ld_div;
    logic              ld_ready;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;

    clk_div_gen #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync     (sync),
        .ld_valid (ld_valid),
        .ld_ch    (ld_ch),
        .ld_div   (ld_div),
        .ld_ready (ld_ready),
        .tick     (tick),
        .clk_out  (clk_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic last_ready;
    logic [NUM_CH-1:0] tick_or;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: per channel, position in period, ratio and one load slot.
    int m_cnt [NUM_CH];
    int m_div [NUM_CH];
    int m_pdiv[NUM_CH];
    bit m_pend[NUM_CH];
    bit m_tick[NUM_CH];
    bit m_clk [NUM_CH];

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0; m_div[c] = DEFAULT_DIV; m_pdiv[c] = 0;
            m_pend[c] = 1'b0; m_tick[c] = 1'b0; m_clk[c] = 1'b0;
        end
    endfunction

    function automatic bit model_ready(input int lc);
        if (lc >= NUM_CH) return 1'b0;
        return !m_pend[lc];
    endfunction

    function automatic void model_edge(input logic [NUM_CH-1:0] e, input logic s,
                                       input logic lv, input int lc, input int ld);
        bit accept;
        bit active;
        bit done;
        accept = lv && model_ready(lc);
        for (int c = 0; c < NUM_CH; c++) begin
            active = e[c] && (m_div[c] > 0);
            done   = !s && active && (m_cnt[c] == m_div[c] - 1);
            m_tick[c] = done;
            if (done) m_clk[c] = !m_clk[c];
            if (m_pend[c] && (s || done || !active)) begin
                m_div[c]  = m_pdiv[c];
                m_pend[c] = 1'b0;
                m_cnt[c]  = 0;
            end else if (s) begin
                m_cnt[c] = 0;
            end else if (active) begin
                m_cnt[c] = (m_cnt[c] + 1) % m_div[c];
            end
        end
        if (accept) begin
            m_pend[lc] = 1'b1;
            m_pdiv[lc] = ld;
        end
    endfunction

    function automatic logic [NUM_CH-1:0] model_tick();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_tick[c];
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] model_clk();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_clk[c] & TOGGLE;
        return v;
    endfunction

    // One clock: drive inputs, check ld_ready before the edge, tick/clk_out after it.
    task automatic step(input logic [NUM_CH-1:0] e, input logic s, input logic lv,
                        input logic [1:0] lc, input logic [CNT_W-1:0] ld);
        en = e; sync = s; ld_valid = lv; ld_ch = lc; ld_div = ld;
        #1;
        last_ready = ld_ready;
        check("ld_ready", 32'(ld_ready), 32'(model_ready(int'(lc))));
        @(posedge clk);
        model_edge(e, s, lv, int'(lc), int'(ld));
        #1;
        cyc++;
        tick_or |= tick;
        check("tick", 32'(tick), 32'(model_tick()));
        check("clk_out", 32'(clk_out), 32'(model_clk()));
    endtask

    task automatic idle(input logic [NUM_CH-1:0] e, input int n);
        for (int i = 0; i < n; i++) step(e, 1'b0, 1'b0, 2'd0, '0);
    endtask

    task automatic run_until_tick(input logic [NUM_CH-1:0] e, input int ch, input int limit,
                                  output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step(e, 1'b0, 1'b0, 2'd0, '0);
            if (tick[ch]) begin
                n = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic [NUM_CH-1:0] en;
        logic              ldv;
        logic [1:0]        ch;
        logic [CNT_W-1:0]  div;
        logic              exp_ready;
        logic [NUM_CH-1:0] exp_tick;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int n;
        int t_edge[3];
        int found;
        logic prev;
        logic [NUM_CH-1:0] r_en;
        logic r_sync, r_lv;
        logic [1:0] r_lc;
        logic [CNT_W-1:0] r_ld;

        // Ratio 1 -> 0 -> 2 on channel 2 and an out-of-range load, others disabled.
        vecs[0]  = '{3'b000, 1'b1, 2'd2, 16'd1, 1'b1, 3'b000};
        vecs[1]  = '{3'b000, 1'b0, 2'd2, 16'd0, 1'b0, 3'b000};
        vecs[2]  = '{3'b100, 1'b0, 2'd2, 16'd0, 1'b1, 3'b100};
        vecs[3]  = '{3'b100, 1'b0, 2'd2, 16'd0, 1'b1, 3'b100};
        vecs[4]  = '{3'b100, 1'b1, 2'd2, 16'd0, 1'b1, 3'b100};
        vecs[5]  = '{3'b100, 1'b0, 2'd2, 16'd0, 1'b0, 3'b100};
        vecs[6]  = '{3'b100, 1'b0, 2'd2, 16'd0, 1'b1, 3'b000};
        vecs[7]  = '{3'b100, 1'b0, 2'd2, 16'd0, 1'b1, 3'b000};
        vecs[8]  = '{3'b100, 1'b1, 2'd2, 16'd2, 1'b1, 3'b000};
        vecs[9]  = '{3'b100, 1'b0, 2'd2, 16'd0, 1'b0, 3'b000};
        vecs[10] = '{3'b100, 1'b0, 2'd2, 16'd0, 1'b1, 3'b000};
        vecs[11] = '{3'b100, 1'b0, 2'd2, 16'd0, 1'b1, 3'b100};
        vecs[12] = '{3'b100, 1'b1, 2'd3, 16'd9, 1'b0, 3'b000};
        vecs[13] = '{3'b100, 1'b0, 2'd2, 16'd0, 1'b1, 3'b100};
        vecs[14] = '{3'b000, 1'b0, 2'd2, 16'd0, 1'b1, 3'b000};

        en = '0; sync = 1'b0; ld_valid = 1'b0; ld_ch = 2'd0; ld_div = '0;
        tick_or = '0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset tick", 32'(tick), 32'd0);
        check("reset clk_out", 32'(clk_out), 32'd0);
        check("reset ld_ready", 32'(ld_ready), 32'd1);
        rst_n = 1'b1;

        // Default ratio: first tick 1000 edges after reset release, channel 1 silent.
        tick_or = '0;
        run_until_tick(3'b001, 0, 1100, n);
        check("first default tick", 32'(n), 32'd1000);
        check("idle channel 1 tick", 32'(tick_or[1]), 32'd0);

        // Mid-period load at cnt=300, second load blocked, new ratio starts after the 999 wrap.
        idle(3'b001, 300);
        step(3'b001, 1'b0, 1'b1, 2'd0, 16'd4);
        step(3'b001, 1'b0, 1'b1, 2'd0, 16'd9);
        check("second load blocked", 32'(last_ready), 32'd0);
        run_until_tick(3'b001, 0, 1100, n);
        check("old period completes", 32'(n), 32'd698);
        run_until_tick(3'b001, 0, 20, n);
        check("new ratio period 1", 32'(n), 32'd4);
        run_until_tick(3'b001, 0, 20, n);
        check("new ratio period 2", 32'(n), 32'd4);

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].en, 1'b0, vecs[i].ldv, vecs[i].ch, vecs[i].div);
            check($sformatf("vec%0d ready", i), 32'(last_ready), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d tick", i), 32'(tick), 32'(vecs[i].exp_tick));
        end

        // Ratios 3 and 5 out of phase, then sync with a load arriving on the sync edge.
        step(3'b000, 1'b0, 1'b1, 2'd0, 16'd3);
        step(3'b000, 1'b0, 1'b1, 2'd1, 16'd5);
        step(3'b000, 1'b0, 1'b0, 2'd0, 16'd0);
        idle(3'b001, 2);
        idle(3'b011, 6);
        step(3'b011, 1'b1, 1'b1, 2'd0, 16'd7);
        check("sync suppresses tick", 32'(tick), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            logic [1:0] exp2;
            step(3'b011, 1'b0, 1'b0, 2'd0, '0);
            if (k == 1) check("load on sync pending", 32'(last_ready), 32'd0);
            exp2 = {(k == 5 || k == 10), (k == 3 || k == 10)};
            check($sformatf("post-sync +%0d", k), 32'(tick[1:0]), 32'(exp2));
        end

        // Divided clock on channel 1 (ratio 5).
        found = 0;
        prev = clk_out[1];
        for (int i = 0; i < 60 && found < 3; i++) begin
            step(3'b011, 1'b0, 1'b0, 2'd0, '0);
            if (clk_out[1] !== prev) begin
                t_edge[found] = cyc;
                found++;
                prev = clk_out[1];
            end
        end
`ifdef CLK_DIV_TOGGLE_EN
        check("clk_out period", (found == 3) ? 32'(t_edge[2] - t_edge[0]) : 32'hFFFF_FFFF, 32'd10);
`else
        check("clk_out stays low", 32'(found), 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            r_en   = NUM_CH'($urandom) | NUM_CH'($urandom);
            r_sync = ($urandom_range(0, 24) == 0);
            r_lv   = ($urandom_range(0, 3) == 0);
            r_lc   = 2'($urandom_range(0, 3));
            r_ld   = CNT_W'($urandom_range(0, 9));
            step(r_en, r_sync, r_lv, r_lc, r_ld);
        end

        // Asynchronous reset with a load pending on channel 0.
        step(3'b000, 1'b0, 1'b1, 2'd0, 16'd20);
        step(3'b000, 1'b0, 1'b0, 2'd0, 16'd0);
        step(3'b001, 1'b0, 1'b1, 2'd0, 16'd50);
        step(3'b001, 1'b0, 1'b0, 2'd0, 16'd0);
        check("pending before reset", 32'(last_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async reset tick", 32'(tick), 32'd0);
        check("async reset clk_out", 32'(clk_out), 32'd0);
        check("async reset ld_ready", 32'(ld_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_until_tick(3'b001, 0, 1100, n);
        check("restart default tick", 32'(n), 32'd1000);
        run_until_tick(3'b001, 0, 1100, n);
        check("pending load discarded", 32'(n), 32'd1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of independent divider channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16, meaning divide-counter width in bits.
REQ-003 SHALL have parameter DEFAULT_DIV, default 1000, meaning per-channel divide ratio loaded at reset (1..2^CNT_W-1).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port en  input  NUM_CH  per-channel count enable.
REQ-007 SHALL have port sync  input  1  one-cycle pulse realigning all channels.
REQ-008 SHALL have port ld_valid  input  1  divide-ratio load request.
REQ-009 SHALL have port ld_ch  input  clog2(NUM_CH) (min 1)  target channel of load.
REQ-010 SHALL have port ld_div  input  CNT_W  new divide ratio.
REQ-011 SHALL have port ld_ready  output  1  load can be accepted for ld_ch.
REQ-012 SHALL have port tick  output  NUM_CH  registered one-cycle strobe per channel period.
REQ-013 SHALL have port clk_out  output  NUM_CH  registered divided square wave per channel.

Function
REQ-014 Each channel SHALL hold cnt and div_reg; when en[i]=1 and div_reg>=1, cnt increments each cycle and wraps to 0 after reaching div_reg-1.
REQ-015 tick[i] SHALL be 1 in the cycle after the edge at which cnt==div_reg-1 with en[i]=1; otherwise 0; latency one cycle.
REQ-016 div_reg=1 SHALL give tick[i]=1 every cycle en[i] is high; div_reg=0 SHALL halt the channel (cnt held at 0, tick 0).
REQ-017 en[i]=0 SHALL freeze cnt and clk_out[i] and force tick[i]=0 next cycle; re-enable resumes from frozen cnt.
REQ-018 Load handshake: transfer when ld_valid && ld_ready on the same edge; ld_ready = NOT pending[ld_ch] (combinational on ld_ch).
REQ-019 Accepted ld_div SHALL be stored in pend_div[ld_ch], pending set; ld_ch >= NUM_CH SHALL be ignored, ld_ready=0 for it.
REQ-020 Pending value SHALL apply (div_reg<=pend_div, cnt<=0, pending cleared) at the channel's next wrap, or on the next edge if en[i]=0 or div_reg=0.
REQ-021 sync=1 SHALL on that edge set every cnt to 0, apply all pending loads, suppress tick that cycle; clk_out unchanged.
REQ-022 Load accepted on the same edge as sync SHALL become pending and apply at the following wrap, not at this sync.
REQ-023 Wrap and pending application on the same edge SHALL produce the tick for the old period, then count with the new ratio.
REQ-024 No arithmetic overflow: cnt compares against div_reg-1 only when div_reg>=1.

Reset
REQ-025 rst_n=0 SHALL immediately set cnt=0, div_reg=DEFAULT_DIV, pending=0, pend_div=0, tick=0, clk_out=0; ld_ready then reads 1.
REQ-026 Reset mid-period or with a load pending SHALL discard the pending load; counting restarts from 0 on the first edge after rst_n rises.

Configuration
REQ-027 Macro CLK_DIV_TOGGLE_EN defined: clk_out[i] SHALL toggle on each tick[i] edge, giving period 2*div_reg cycles, 50% duty.
REQ-028 Macro CLK_DIV_TOGGLE_EN undefined: clk_out SHALL be constant 0, toggle flops absent; port list unchanged.

Structure
REQ-029 Package clk_div_pkg SHALL hold CNT_W and DEFAULT_DIV default constants and the channel-index width function.
REQ-030 Sub-module clk_div_chan SHALL implement one channel (cnt, div_reg, pending, tick, clk_out), instantiated NUM_CH times; top does load decode and sync fan-out.

Verification
REQ-031 Reset, en=2'b01, DEFAULT_DIV=1000 -> tick[0] every 1000 cycles, first 1000 cycles after rst_n rises; tick[1]=0.
REQ-032 Load ld_ch=0 ld_div=4 mid-period at cnt=300 -> ld_ready[ch0]=0 until cnt wraps at 999, then ticks every 4 cycles; second load blocked while pending.
REQ-033 div=1 en=1 -> tick constant 1; div=0 load -> tick 0 forever, next load applies on following edge.
REQ-034 Channels div 3 and 5 out of phase, sync pulse -> both cnt=0, no tick that cycle, ticks at +3 and +5 cycles thereafter; load on sync edge deferred.
REQ-035 CLK_DIV_TOGGLE_EN defined, div=5 -> clk_out period 10 cycles; undefined -> clk_out stays 0.
REQ-036 rst_n low asynchronously mid-period with pending load -> outputs zero without clock edge; DEFAULT_DIV restored, pending lost.
